// File: rtl/dmx_writer.sv
// dmx_writer: DMX512 frame generator (break, mark-after-break, start code, then
// NUM_SLOTS channel slots at 250 kbaud, 8N2). Before each channel slot it
// requests the byte from the data processor and latches the registered reply.
// Optional build macro DMX_FIXTURE_DEFAULTS_EN: channels 3 and 5 transmit fixed
// fixture defaults instead of the processor reply.
module dmx_writer #(
  parameter int CLKS_PER_BIT = 108,
  parameter int BREAK_BITS   = 25,
  parameter int MAB_BITS     = 3,
  parameter int NUM_SLOTS    = 511
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic [8:0] request_addr,
  output logic       request_pulse,
  input  logic [8:0] addr_in,
  input  logic [7:0] data_in,
  output logic       dmx_out,
  output logic       busy,
  output logic       frame_done,
  output logic       addr_err
);

  localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BMAX = (BREAK_BITS > MAB_BITS) ? BREAK_BITS : MAB_BITS;
  localparam int BW   = (BMAX > 16) ? $clog2(BMAX + 1) : 5;

  typedef enum logic [2:0] {
    S_IDLE, S_BREAK, S_MAB, S_SLOT, S_FETCH0, S_FETCH1, S_FETCH2
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   clk_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [8:0]      slot_cnt;   // data slots already sent in this frame
  logic [7:0]      tx_byte;
  logic [10:0]     frame_bits;
  logic            bit_end;
  logic            timed;
  logic [7:0]      fetch_byte;
  logic            fetch_err;

  assign bit_end    = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign timed      = (state == S_BREAK) || (state == S_MAB) || (state == S_SLOT);
  // Serial order on the wire, index 0 first: start, D0..D7, stop, stop.
  assign frame_bits = {2'b11, tx_byte, 1'b0};

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (enable) next_state = S_BREAK;
      S_BREAK:  if (bit_end && bit_cnt == BW'(BREAK_BITS - 1)) next_state = S_MAB;
      S_MAB:    if (bit_end && bit_cnt == BW'(MAB_BITS - 1)) next_state = S_SLOT;
      S_SLOT:   if (bit_end && bit_cnt == BW'(10))
                  next_state = (slot_cnt < 9'(NUM_SLOTS)) ? S_FETCH0 : S_IDLE;
      S_FETCH0: next_state = S_FETCH1;
      S_FETCH1: next_state = S_FETCH2;
      S_FETCH2: next_state = S_SLOT;
      default:  next_state = S_IDLE;
    endcase
  end

  // Line, strobe and busy outputs decoded from state
  always_comb begin
    dmx_out       = 1'b1;
    request_pulse = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_BREAK:  dmx_out = 1'b0;
      S_SLOT:   dmx_out = frame_bits[bit_cnt[3:0]];
      S_FETCH0: request_pulse = 1'b1;
      default:  ;
    endcase
  end

  // Reply selection: mismatched replies are replaced by zero so a bad
  // address never drives a wrong fixture with someone else's data.
  always_comb begin
    fetch_byte = data_in;
    fetch_err  = (addr_in != request_addr);
`ifdef DMX_FIXTURE_DEFAULTS_EN
    if (request_addr == 9'd3) begin
      fetch_byte = 8'd120;   // color wheel
      fetch_err  = 1'b0;
    end else if (request_addr == 9'd5) begin
      fetch_byte = 8'd100;   // dimmer
      fetch_err  = 1'b0;
    end
`endif
    if (fetch_err) fetch_byte = 8'h00;
  end

  // Bit/slot counters, shift byte, request address and status flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      slot_cnt     <= '0;
      tx_byte      <= '0;
      request_addr <= '0;
      frame_done   <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      frame_done <= (state == S_SLOT) && (next_state == S_IDLE);

      if (state != next_state || !timed) begin
        clk_cnt <= '0;
        bit_cnt <= '0;
      end else if (bit_end) begin
        clk_cnt <= '0;
        bit_cnt <= bit_cnt + BW'(1);
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end

      case (state)
        S_IDLE:   if (next_state == S_BREAK) begin
                    addr_err <= 1'b0;
                    slot_cnt <= '0;
                  end
        S_MAB:    if (next_state == S_SLOT) tx_byte <= 8'h00;  // start code
        S_SLOT:   if (next_state == S_FETCH0) begin
                    slot_cnt     <= slot_cnt + 9'd1;
                    request_addr <= slot_cnt + 9'd1;
                  end
        S_FETCH2: begin
                    tx_byte <= fetch_byte;
                    if (fetch_err) addr_err <= 1'b1;
                  end
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmx_writer.sv
// tb_dmx_writer: random-data frame checks of dmx_writer against a line-level
// model of the DMX frame built from break/MAB/slot lengths and channel bytes.
module tb_dmx_writer;

  localparam int CPB = 4;
  localparam int BRK = 22;
  localparam int MAB = 2;
`ifdef DMX_FIXTURE_DEFAULTS_EN
  localparam int NS  = 5;
`else
  localparam int NS  = 3;
`endif
  localparam int FL   = (BRK + MAB) * CPB + 11 * CPB * (NS + 1) + 3 * NS;
  localparam int SLOT0 = (BRK + MAB) * CPB;
  localparam int SPAN  = 11 * CPB + 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [8:0] request_addr;
  logic       request_pulse;
  logic [8:0] addr_in;
  logic [7:0] data_in;
  logic       dmx_out;
  logic       busy;
  logic       frame_done;
  logic       addr_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] tbl [0:511];
  int corrupt_ch = 0;

  dmx_writer #(.CLKS_PER_BIT(CPB), .BREAK_BITS(BRK), .MAB_BITS(MAB), .NUM_SLOTS(NS)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .request_addr(request_addr), .request_pulse(request_pulse),
    .addr_in(addr_in), .data_in(data_in), .dmx_out(dmx_out),
    .busy(busy), .frame_done(frame_done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Processor model: registers and holds its reply on each request.
  always @(posedge clk) begin
    if (request_pulse) begin
      addr_in <= (request_addr == 9'(corrupt_ch)) ? request_addr + 9'd1 : request_addr;
      data_in <= tbl[request_addr];
    end
  end

  function automatic logic [7:0] exp_byte(input int ch);
`ifdef DMX_FIXTURE_DEFAULTS_EN
    if (ch == 3) return 8'd120;
    if (ch == 5) return 8'd100;
`endif
    if (ch == corrupt_ch) return 8'h00;
    return tbl[ch];
  endfunction

  // Captures one frame from BREAK entry and checks line, requests and flags.
  task automatic run_frame(input int drop_at, input bit exp_err, input int exp_gap);
    logic [FL-1:0] cap, expw;
    int t, k, bad_busy, rq_n;
    int rq_at [$];
    int rq_ad [$];
    logic [7:0] b, dec;
    t = 0;
    while (busy !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL frame_start: busy=%b required 1 within 2000 clocks", busy);
      return;
    end
    if (exp_gap >= 0) begin
      n_checks++;
      if (t !== exp_gap) begin n_fail++; $display("FAIL frame_gap: %0d clocks, required %0d", t, exp_gap); end
    end
    bad_busy = 0;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) @(negedge clk);
      cap[i] = dmx_out;
      if (busy !== 1'b1 || frame_done !== 1'b0) bad_busy++;
      if (request_pulse === 1'b1) begin rq_at.push_back(i); rq_ad.push_back(int'(request_addr)); end
      if (i == 0) begin
        n_checks++;
        if (addr_err !== 1'b0) begin n_fail++; $display("FAIL addr_err_clear: %b at BREAK entry, required 0", addr_err); end
      end
      if (i == drop_at) enable = 1'b0;
    end
    n_checks++;
    if (bad_busy != 0) begin n_fail++; $display("FAIL busy_in_frame: %0d bad clocks, required 0", bad_busy); end
    n_checks++;
    if (addr_err !== exp_err) begin n_fail++; $display("FAIL addr_err_end: %b required %b", addr_err, exp_err); end
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL frame_done: done=%b busy=%b required done=1 busy=0", frame_done, busy); end
    // Expected line: break, MAB, then each slot (3 mark clocks ahead of data slots).
    k = 0;
    for (int i = 0; i < BRK * CPB; i++) expw[k++] = 1'b0;
    for (int i = 0; i < MAB * CPB; i++) expw[k++] = 1'b1;
    for (int s = 0; s <= NS; s++) begin
      if (s > 0) for (int i = 0; i < 3; i++) expw[k++] = 1'b1;
      b = (s == 0) ? 8'h00 : exp_byte(s);
      for (int j = 0; j < 11; j++)
        for (int c = 0; c < CPB; c++)
          expw[k++] = (j == 0) ? 1'b0 : (j > 8) ? 1'b1 : b[j-1];
    end
    n_checks++;
    if (cap !== expw) begin n_fail++; $display("FAIL line_wave: got %h required %h", cap, expw); end
    // Decode each data slot at mid-bit.
    for (int s = 1; s <= NS; s++) begin
      for (int j = 0; j < 8; j++) dec[j] = cap[SLOT0 + s * SPAN + (j + 1) * CPB + CPB / 2];
      n_checks++;
      if (dec !== exp_byte(s)) begin n_fail++; $display("FAIL slot%0d_byte: %h required %h", s, dec, exp_byte(s)); end
    end
    rq_n = rq_at.size();
    n_checks++;
    if (rq_n != NS) begin n_fail++; $display("FAIL request_count: %0d required %0d", rq_n, NS); end
    else for (int r = 0; r < NS; r++) begin
      n_checks++;
      if (rq_ad[r] != r + 1 || rq_at[r] != SLOT0 + (r + 1) * SPAN - 3) begin
        n_fail++;
        $display("FAIL request%0d: addr %0d at clk %0d, required addr %0d at clk %0d",
                 r + 1, rq_ad[r], rq_at[r], r + 1, SLOT0 + (r + 1) * SPAN - 3);
      end
    end
  endtask

  task automatic test_reset;
    enable = 1'b0; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dmx_out !== 1'b1 || busy !== 1'b0 || request_pulse !== 1'b0 || frame_done !== 1'b0 || addr_err !== 1'b0)
      begin n_fail++; $display("FAIL reset_outputs: dmx=%b busy=%b req=%b done=%b err=%b required 1 0 0 0 0",
                               dmx_out, busy, request_pulse, frame_done, addr_err); end
    n_checks++;
    if (request_addr !== 9'd0) begin n_fail++; $display("FAIL reset_addr: %0d required 0", request_addr); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (dmx_out !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_disabled: dmx=%b busy=%b required 1 0", dmx_out, busy); end
  endtask

  task automatic test_frame;
    for (int c = 0; c < 512; c++) tbl[c] = 8'(8'h10 + c);
`ifdef DMX_FIXTURE_DEFAULTS_EN
    for (int c = 0; c < 512; c++) tbl[c] = 8'hFF;
`endif
    enable = 1'b1;
    run_frame(-1, 1'b0, 1);
  endtask

  task automatic test_back_to_back;
    run_frame(-1, 1'b0, 1);
  endtask

  task automatic test_random_data;
    for (int c = 0; c < 512; c++) tbl[c] = 8'($urandom);
    run_frame(-1, 1'b0, 1);
  endtask

  task automatic test_addr_err;
    corrupt_ch = 2;
    run_frame(-1, 1'b1, 1);
    corrupt_ch = 0;
    run_frame(-1, 1'b0, 1);
  endtask

  task automatic test_enable_drop;
    int bad;
    run_frame(SLOT0 + SPAN + $urandom_range(0, 11 * CPB - 1), 1'b0, 1);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (dmx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL idle_after_drop: %0d bad clocks, required 0", bad); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_break;
    int t;
    t = 0;
    while (busy !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    repeat ($urandom_range(5, 60)) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dmx_out !== 1'b1 || busy !== 1'b0 || request_pulse !== 1'b0)
      begin n_fail++; $display("FAIL reset_mid_break: dmx=%b busy=%b req=%b required 1 0 0", dmx_out, busy, request_pulse); end
    reset_n = 1'b1;
    run_frame(-1, 1'b0, 1);
  endtask

  initial begin
    addr_in = '0; data_in = '0;
    test_reset();
    test_frame();
    test_back_to_back();
    test_random_data();
`ifndef DMX_FIXTURE_DEFAULTS_EN
    test_addr_err();
`endif
    test_enable_drop();
    test_reset_mid_break();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmx_writer.md
Name: dmx_writer

Overview:
- Downstream consumer of the DMX data processor: generates the DMX512 frame and drives the serial line toward the RS-485 transceiver.
- Before each channel slot it pulses a request with the channel address, waits for the processor's registered address/data reply, latches the byte and shifts it out (250 kbaud, 8N2).
- Frames repeat back-to-back while enable is high.

Parameters:
- CLKS_PER_BIT, 108, clocks per 4 us DMX bit (27 MHz / 250 kbaud); legal >= 2
- BREAK_BITS, 25, break length in bit-times (100 us at default); legal >= 22
- MAB_BITS, 3, mark-after-break length in bit-times (12 us); legal >= 2
- NUM_SLOTS, 511, channel slots per frame after the start code; legal 1..511

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  level; high = transmit frames continuously
- request_addr  out  9  channel number being requested (1..NUM_SLOTS)
- request_pulse  out  1  one-clock request strobe to processor
- addr_in  in  9  processor reply address (registered, valid 1 clock after request_pulse)
- data_in  in  8  processor reply data (same timing as addr_in)
- dmx_out  out  1  serial DMX line, idle/mark = 1
- busy  out  1  high from BREAK entry through end of last stop bit
- frame_done  out  1  one-clock pulse after last stop bit of the last slot
- addr_err  out  1  sticky; set on reply address mismatch, cleared at next BREAK entry

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset values (reset_n sampled low at any clk edge, including mid-frame): state IDLE, dmx_out=1, request_pulse=0, request_addr=0, busy=0, frame_done=0, addr_err=0. Bit/slot counters are cleared. The frame is abandoned; no partial slot completes.
- States: IDLE, BREAK, MAB, SLOT, FETCH0, FETCH1, FETCH2.
- IDLE:
  - dmx_out=1.
  - If enable=1, go to BREAK on the next edge, clear addr_err and set busy.
- BREAK: dmx_out=0 for exactly BREAK_BITS*CLKS_PER_BIT clocks, then MAB.
- MAB: dmx_out=1 for exactly MAB_BITS*CLKS_PER_BIT clocks, then SLOT with the start code (0x00). No fetch is made for the start code.
- SLOT:
  - 11 bits of CLKS_PER_BIT clocks each: start bit 0, 8 data bits LSB first, 2 stop bits 1.
  - After the last stop bit: if slots sent < NUM_SLOTS, go to FETCH0 with channel n = previous+1 (first is 1). Otherwise pulse frame_done, drop busy and go to IDLE.
- FETCH0: request_pulse=1, request_addr=n, dmx_out=1.
- FETCH1: request_pulse=0, dmx_out=1 (processor reply registering).
- FETCH2:
  - Latch data_in into the shift register.
  - If addr_in != n, set addr_err and transmit 0x00 instead of data_in.
  - Go to SLOT.
- Each fetch therefore extends mark-time-between-slots by exactly 3 clocks; the line stays 1, which is legal DMX.
- request_addr holds its value outside FETCH0; it is only meaningful when request_pulse=1.
- Frame length in clocks: (BREAK_BITS+MAB_BITS)*CLKS_PER_BIT + 11*CLKS_PER_BIT*(NUM_SLOTS+1) + 3*NUM_SLOTS.
  - Defaults: 612813 clocks (~22.7 ms).
- enable deasserted mid-frame: the current frame completes fully, then IDLE.
- enable high at frame_done: the next edge after the IDLE entry starts BREAK, so the minimum gap between frames is 1 clock of mark.
- Bit timing counters wrap at CLKS_PER_BIT-1. The slot counter is 9 bits and never exceeds NUM_SLOTS.

Optional Feature:
- Macro: DMX_FIXTURE_DEFAULTS_EN.
- When defined, FETCH2 substitutes fixed values, ignoring data_in/addr_in and never setting addr_err:
  - channel 3 (color wheel) = 8'd120
  - channel 5 (dimmer) = 8'd100
  - The fetch still occurs and timing is unchanged.
- When undefined, all channels use the processor reply.

Test Plan:
- Params CLKS_PER_BIT=4, BREAK_BITS=22, MAB_BITS=2, NUM_SLOTS=3; enable=1; model processor returns data=0x10+addr -> dmx_out low 88 clocks, high 8, start-code slot 44 clocks (0 then eight 0s then 11); slots decode 0x11, 0x12, 0x13; frame_done 281 clocks after BREAK entry.
- Same setup: check request_pulse is exactly 1 clock with request_addr 1, 2, 3 in order, each 2 clocks before latch; no request during start code.
- Model replies addr_in=request_addr+1 for channel 2 -> slot 2 transmits 0x00, addr_err=1 stays set through the frame and clears at the next BREAK entry.
- Drop enable during slot 1 -> frame completes through slot 3, frame_done pulses, dmx_out stays 1 and busy=0 afterward.
- Assert reset_n=0 for 1 clock mid-BREAK -> next clock dmx_out=1, busy=0, request_pulse=0; with enable=1 a fresh full 88-clock break follows.
- DMX_FIXTURE_DEFAULTS_EN defined, NUM_SLOTS=5, processor returns 0xFF everywhere -> slots decode FF, FF, 0x78, FF, 0x64; addr_err stays 0.
